// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package counter_pkg;

  localparam int WRAP_MODE = 0;
  localparam int SAT_MODE  = 1;

  // Load values at or above the modulus collapse onto the top count.
  function automatic int unsigned clamp_to_mod(input int unsigned din, input int unsigned mod);
    return (din < mod) ? din : (mod - 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary-to-Gray encoder; only built when UPDOWN_MOD_COUNTER_GRAY_EN is defined.
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
module bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule
`endif

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate limits, tc and wrap pulse.
// Optional registered Gray output y_gray under UPDOWN_MOD_COUNTER_GRAY_EN.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MOD      = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] y,
  output logic             tc,
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
  output logic [WIDTH-1:0] y_gray,
`endif
  output logic             wrap
);

  if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
    $error("updown_mod_counter: MOD must lie in 2..2**WIDTH");
  end
  if (SATURATE != WRAP_MODE && SATURATE != SAT_MODE) begin : g_bad_sat
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_y;
  logic             r_wrap;
  logic [WIDTH-1:0] w_y_next;
  logic             w_wrap_next;
  logic [WIDTH-1:0] w_load_val;

  assign w_load_val = WIDTH'(clamp_to_mod(32'(din), MOD));

  // Limits are explicit compares against MAX/0, so non-power-of-two MOD wraps cleanly.
  always_comb begin
    w_y_next    = r_y;
    w_wrap_next = 1'b0;
    if (load) begin
      w_y_next = w_load_val;
    end else if (en) begin
      if (up) begin
        if (r_y == MAX) begin
          if (SATURATE == WRAP_MODE) begin
            w_y_next    = '0;
            w_wrap_next = 1'b1;
          end
        end else begin
          w_y_next = r_y + WIDTH'(1);
        end
      end else begin
        if (r_y == '0) begin
          if (SATURATE == WRAP_MODE) begin
            w_y_next    = MAX;
            w_wrap_next = 1'b1;
          end
        end else begin
          w_y_next = r_y - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_y    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_y    <= w_y_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign y    = r_y;
  assign wrap = r_wrap;
  assign tc   = up ? (r_y == MAX) : (r_y == '0);

`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] r_gray;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .i_bin  (w_y_next),
    .o_gray (w_gray_next)
  );

  // Encoding the next count keeps y_gray on the same cycle as y.
  always_ff @(posedge clk) begin
    if (!rst) r_gray <= '0;
    else      r_gray <= w_gray_next;
  end

  assign y_gray = r_gray;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: three counter configurations driven one at a time, expectations queued per step.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_a   [3];
  logic       up_a   [3];
  logic       load_a [3];
  logic [2:0] din_a  [3];
  logic [2:0] y_a    [3];
  logic       tc_a   [3];
  logic       wrap_a [3];
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
  logic [2:0] g_a    [3];
`endif

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(0)) u_m8 (
    .clk(clk), .rst(rst), .en(en_a[0]), .up(up_a[0]), .load(load_a[0]), .din(din_a[0]),
    .y(y_a[0]), .tc(tc_a[0]),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    .y_gray(g_a[0]),
`endif
    .wrap(wrap_a[0])
  );

  updown_mod_counter #(.WIDTH(3), .MOD(6), .SATURATE(0)) u_m6 (
    .clk(clk), .rst(rst), .en(en_a[1]), .up(up_a[1]), .load(load_a[1]), .din(din_a[1]),
    .y(y_a[1]), .tc(tc_a[1]),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    .y_gray(g_a[1]),
`endif
    .wrap(wrap_a[1])
  );

  updown_mod_counter #(.WIDTH(3), .MOD(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en_a[2]), .up(up_a[2]), .load(load_a[2]), .din(din_a[2]),
    .y(y_a[2]), .tc(tc_a[2]),
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    .y_gray(g_a[2]),
`endif
    .wrap(wrap_a[2])
  );

  typedef struct {
    int         k;
    logic [2:0] y;
    logic       w;
    logic       tc;
    logic [2:0] g;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instance for one edge (others idle), queue the expectation, then check it.
  task automatic step(input logic r, input int k, input logic e, input logic u, input logic l,
                      input logic [2:0] d, input logic [2:0] ey, input logic ew, input logic et,
                      input logic [2:0] eg, input string tag);
    exp_t x;
    rst = r;
    for (int i = 0; i < 3; i++) begin
      en_a[i]   = 1'b0;
      load_a[i] = 1'b0;
    end
    en_a[k]   = e;
    up_a[k]   = u;
    load_a[k] = l;
    din_a[k]  = d;
    x = '{k: k, y: ey, w: ew, tc: et, g: eg, tag: tag};
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk({x.tag, ".y"},    32'(y_a[x.k]),    32'(x.y));
    chk({x.tag, ".wrap"}, 32'(wrap_a[x.k]), 32'(x.w));
    chk({x.tag, ".tc"},   32'(tc_a[x.k]),   32'(x.tc));
`ifdef UPDOWN_MOD_COUNTER_GRAY_EN
    if (x.k == 0) chk({x.tag, ".gray"}, 32'(g_a[0]), 32'(x.g));
`endif
  endtask

  logic [2:0] upseq [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
  logic [2:0] gseq  [9] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1};
  logic [2:0] dnseq [7] = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5};

  initial begin
    for (int i = 0; i < 3; i++) begin
      en_a[i] = 1'b0; up_a[i] = 1'b1; load_a[i] = 1'b0; din_a[i] = 3'd0;
    end

    // Reset dominates a simultaneous load and enable.
    step(1'b0, 0, 1'b1, 1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b1, 3'd0, "rst");
    chk("rst.m6.y",  32'(y_a[1]), 32'd0);
    chk("rst.sat.y", 32'(y_a[2]), 32'd0);
    up_a[0] = 1'b1;
    #1;
    chk("rst.tc_up", 32'(tc_a[0]), 32'd0);

    // Up count through the wrap on MOD=8.
    for (int i = 0; i < 9; i++)
      step(1'b1, 0, 1'b1, 1'b1, 1'b0, 3'd0, upseq[i], (i == 7), (upseq[i] == 3'd7), gseq[i],
           $sformatf("up%0d", i));
    step(1'b1, 0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 3'd1, "hold");

    // Down count on MOD=6 wraps 0 -> 5.
    step(1'b1, 1, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, "m6.ld0");
    for (int i = 0; i < 7; i++)
      step(1'b1, 1, 1'b1, 1'b0, 1'b0, 3'd0, dnseq[i], (i == 0 || i == 6), (dnseq[i] == 3'd0),
           3'd0, $sformatf("dn%0d", i));

    // Load beats enable and clamps to MOD-1; then up wraps 5 -> 0.
    step(1'b1, 1, 1'b1, 1'b1, 1'b1, 3'd7, 3'd5, 1'b0, 1'b1, 3'd0, "m6.clamp");
    step(1'b1, 1, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, "m6.wrapup");

    // Saturation at both limits.
    step(1'b1, 2, 1'b0, 1'b1, 1'b1, 3'd6, 3'd6, 1'b0, 1'b0, 3'd0, "sat.ld6");
    for (int i = 0; i < 4; i++)
      step(1'b1, 2, 1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 1'b1, 3'd0, $sformatf("sat%0d", i));
    step(1'b1, 2, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, "sat.ld0");
    step(1'b1, 2, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0, "sat.dn");

    // Reset at the point a wrap would occur suppresses it.
    step(1'b1, 0, 1'b0, 1'b1, 1'b1, 3'd7, 3'd7, 1'b0, 1'b1, 3'd4, "ld7");
    step(1'b0, 0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, "midrst");
    step(1'b1, 0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd1, 1'b0, 1'b0, 3'd1, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous modulo counter: next generation of the team's 3-bit "count on w" FSM. It adds:
- configurable width and modulus
- up/down direction
- synchronous parallel load
- wrap or saturate mode
- terminal-count and wrap indications

It serves as a generic sequencer/timer core for the TRF-series designs.

## Interface
Parameters:
- WIDTH, 3, counter/state width in bits
- MOD, 8, count modulus; legal range 2..2**WIDTH, elaboration error otherwise
- SATURATE, 0, 0 = wrap at the limits, 1 = hold at the limits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  count enable (the former w input)
- up  in  1  direction, 1 = increment, 0 = decrement
- load  in  1  synchronous parallel load request
- din  in  WIDTH  load value
- y  out  WIDTH  current count (registered)
- tc  out  1  terminal count, combinational
- wrap  out  1  one-cycle wrap pulse (registered)

## Operation
- The state is the count value y, 0..MOD-1.
- Priority per rising edge: rst==0 > load > en > hold.
- Reset (rst==0 at edge): y=0, wrap=0. The reset value of tc follows from y=0: tc = ~up.
- Load: y <= din when din < MOD, else y <= MOD-1 (clamp); wrap <= 0. Load wins over en in the same cycle.
- en=1, up=1, y < MOD-1: y <= y+1.
- en=1, up=1, y == MOD-1:
  - wrap mode: y <= 0, wrap <= 1.
  - saturate mode: y holds, wrap <= 0.
- en=1, up=0, y > 0: y <= y-1.
- en=1, up=0, y == 0:
  - wrap mode: y <= MOD-1, wrap <= 1.
  - saturate mode: y holds, wrap <= 0.
- en=0 and load=0: y holds, wrap <= 0.
- tc = (up & y==MOD-1) | (~up & y==0); independent of en and SATURATE.
- Arithmetic is WIDTH bits with explicit compare against MOD-1. No reliance on natural 2**WIDTH overflow, so non-power-of-two MOD wraps correctly.

## Timing
- Latency: count, load and reset are visible on y one clock after the sampling edge.
- wrap is high for exactly the cycle in which y shows the wrapped value. Consecutive wraps (MOD=2, continuous en) give a wrap high on every wrapping edge.
- tc changes combinationally with up, with no clock delay.
- Reset mid-count: the next edge forces y=0 regardless of en/load/din and clears a pending wrap.
- A direction change takes effect on the next enabled edge; there is no pipeline to flush.

## Configuration
- Macro: UPDOWN_MOD_COUNTER_GRAY_EN.
- Defined:
  - Adds output port y_gray (WIDTH), a registered Gray code of the next count (y_next ^ (y_next >> 1)), so it is cycle-aligned with y.
  - Reset value of y_gray: 0.
  - Single-bit-change at wrap is guaranteed only when MOD == 2**WIDTH.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package counter_pkg holds:
  - the limit-mode constants WRAP_MODE=0 and SAT_MODE=1
  - a function computing the clamp of din against MOD
- Sub-module bin2gray (parametrised by WIDTH) implements the Gray encoder and is instantiated only under UPDOWN_MOD_COUNTER_GRAY_EN.
- The top module holds the count register, next-state logic, tc and wrap.

## Test plan
- Reset: rst=0 for one edge with en=1, load=1, din=5 -> y=0, wrap=0, tc=1 (up=0), tc=0 (up=1).
- Up wrap, defaults: rst=1, en=1, up=1 for 9 edges from 0 -> y steps 1..7 then 0; wrap=1 only in the y=0 cycle; tc=1 while y=7.
- Down with MOD=6: load din=0, then en=1, up=0 -> y = 5,4,3,2,1,0,5; wrap pulses on each 0->5 step.
- Saturate, SATURATE=1: count up from 6 for 4 edges -> y = 7,7,7,7; wrap stays 0; tc=1 from y=7.
- Load priority and clamp, MOD=6: load=1, en=1, din=7 -> y=5; next edge load=0, en=1, up=1 -> y=0, wrap=1.
- Gray, macro defined: count 0..7..0 with up=1 -> y_gray follows 0,1,3,2,6,7,5,4,0; each step changes exactly one bit.
